// File: rtl/image_smooth_3tap.sv
// Horizontal [1 2 1]/4 smoothing of a two-pixels-per-clock RGB stream with edge replication,
// per-line enable latch, line/frame tracking and a sticky mid-line-drop error flag.
module image_smooth_3tap #(
    parameter int unsigned WIDTH  = 768,
    parameter int unsigned HEIGHT = 512,
    localparam int unsigned LineW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             hsync_in,
    input  logic [7:0]       r0_in,
    input  logic [7:0]       g0_in,
    input  logic [7:0]       b0_in,
    input  logic [7:0]       r1_in,
    input  logic [7:0]       g1_in,
    input  logic [7:0]       b1_in,
    output logic             hsync_out,
    output logic [7:0]       r0_out,
    output logic [7:0]       g0_out,
    output logic [7:0]       b0_out,
    output logic [7:0]       r1_out,
    output logic [7:0]       g1_out,
    output logic [7:0]       b1_out,
    output logic [LineW-1:0] line_cnt,
    output logic             frame_done,
    output logic             err
);

    localparam int unsigned Pairs = WIDTH / 2;
    localparam int unsigned ColW  = $clog2(Pairs);

    typedef logic [2:0][7:0] rgb_t;  // index 0 = R, 1 = G, 2 = B
    typedef enum logic [1:0] {StIdle, StFirst, StRun, StFlush} state_e;

    state_e          state_q, state_d;
    logic [ColW-1:0] col_q, col_d;
    rgb_t            cur0_q, cur0_d, cur1_q, cur1_d, prev_q, prev_d;
    logic            en_q, en_d;
    logic            err_q, err_d;
    rgb_t            out0_q, out1_q, px0, px1, in0, in1, nxt;
    logic            valid_q, last_q, frame_done_q;
    logic [LineW-1:0] line_cnt_q, line_eff;
    logic            emit, emit_last, repl, cap;

    assign in0 = {b0_in, g0_in, r0_in};
    assign in1 = {b1_in, g1_in, r1_in};

    function automatic logic [7:0] tap(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
        logic [9:0] s;
        s = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + 10'd2;
        return s[9:2];
    endfunction

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        cur0_d    = cur0_q;
        cur1_d    = cur1_q;
        prev_d    = prev_q;
        en_d      = en_q;
        err_d     = err_q;
        emit      = 1'b0;
        emit_last = 1'b0;
        repl      = 1'b0;
        cap       = 1'b0;
        unique case (state_q)
            StIdle: cap = hsync_in;
            StFirst, StRun: begin
                emit = 1'b1;
                if (hsync_in) begin
                    prev_d  = cur1_q;
                    cur0_d  = in0;
                    cur1_d  = in1;
                    col_d   = col_q + ColW'(1);
                    state_d = (col_q == ColW'(Pairs - 2)) ? StFlush : StRun;
                end else begin
                    // Dropped line: the held pair becomes the line's last pair.
                    emit_last = 1'b1;
                    repl      = 1'b1;
                    err_d     = 1'b1;
                    col_d     = '0;
                    state_d   = StIdle;
                end
            end
            StFlush: begin
                emit      = 1'b1;
                emit_last = 1'b1;
                repl      = 1'b1;
                col_d     = '0;
                state_d   = StIdle;
                cap       = hsync_in;
            end
            default: state_d = StIdle;
        endcase
        if (cap) begin
            cur0_d  = in0;
            cur1_d  = in1;
            prev_d  = in0;  // left-edge replication
            col_d   = '0;
            en_d    = en;
            state_d = StFirst;
        end
    end

    always_comb begin
        nxt = repl ? cur1_q : in0;
        px0 = cur0_q;
        px1 = cur1_q;
        if (en_q) begin
            for (int i = 0; i < 3; i++) begin
                px0[i] = tap(prev_q[i], cur0_q[i], cur1_q[i]);
                px1[i] = tap(cur0_q[i], cur1_q[i], nxt[i]);
            end
        end
    end

    // A line's increment lands one edge after its last pair is registered.
    always_comb begin
        line_eff = line_cnt_q;
        if (last_q) begin
            line_eff = (line_cnt_q == LineW'(HEIGHT - 1)) ? '0 : line_cnt_q + LineW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            col_q        <= '0;
            cur0_q       <= '0;
            cur1_q       <= '0;
            prev_q       <= '0;
            en_q         <= 1'b0;
            err_q        <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            line_cnt_q   <= '0;
            out0_q       <= '0;
            out1_q       <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            cur0_q       <= cur0_d;
            cur1_q       <= cur1_d;
            prev_q       <= prev_d;
            en_q         <= en_d;
            err_q        <= err_d;
            valid_q      <= emit;
            last_q       <= emit_last;
            frame_done_q <= emit_last && (line_eff == LineW'(HEIGHT - 1));
            line_cnt_q   <= line_eff;
            out0_q       <= emit ? px0 : '0;
            out1_q       <= emit ? px1 : '0;
        end
    end

    assign hsync_out  = valid_q;
    assign r0_out     = out0_q[0];
    assign g0_out     = out0_q[1];
    assign b0_out     = out0_q[2];
    assign r1_out     = out1_q[0];
    assign g1_out     = out1_q[1];
    assign b1_out     = out1_q[2];
    assign line_cnt   = line_cnt_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_image_smooth_3tap.sv
// Bench for image_smooth_3tap: directed lines, per-cycle compare against a pixel-array model.
module tb_image_smooth_3tap;

    localparam int W     = 8;
    localparam int H     = 2;
    localparam int P     = W / 2;
    localparam int N     = 1024;
    localparam int NEVER = 1 << 30;

    logic       clk = 1'b0;
    logic       rst, en, hsync_in;
    logic [7:0] r0_in, g0_in, b0_in, r1_in, g1_in, b1_in;
    logic       hsync_out, frame_done, err;
    logic [7:0] r0_out, g0_out, b0_out, r1_out, g1_out, b1_out;
    logic [0:0] line_cnt;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int model_line = 0;
    int err_from = NEVER;
    bit checking = 1'b0;

    bit         ev[N];
    logic [7:0] ed[N][6];
    bit         efd[N];
    int         eline[N];
    logic [7:0] pix[3][W];

    image_smooth_3tap #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .en(en), .hsync_in(hsync_in),
        .r0_in(r0_in), .g0_in(g0_in), .b0_in(b0_in),
        .r1_in(r1_in), .g1_in(g1_in), .b1_in(b1_in),
        .hsync_out(hsync_out),
        .r0_out(r0_out), .g0_out(g0_out), .b0_out(b0_out),
        .r1_out(r1_out), .g1_out(g1_out), .b1_out(b1_out),
        .line_cnt(line_cnt), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // Smoothed value of pixel p of channel ch on a line of w pixels, edges replicated.
    function automatic int smooth(input int ch, input int p, input int w);
        int l, r;
        l = (p > 0) ? p - 1 : 0;
        r = (p < w - 1) ? p + 1 : w - 1;
        return (int'(pix[ch][l]) + 2 * int'(pix[ch][p]) + int'(pix[ch][r]) + 2) / 4;
    endfunction

    always @(negedge clk) begin
        int i;
        logic [7:0] act[6];
        if (checking && cyc < N) begin
            i = cyc;
            act = '{r0_out, g0_out, b0_out, r1_out, g1_out, b1_out};
            check("hsync_out", hsync_out, ev[i]);
            for (int j = 0; j < 6; j++) check($sformatf("data%0d", j), act[j], ev[i] ? ed[i][j] : 0);
            if (ev[i]) check("line_cnt", line_cnt, eline[i]);
            check("frame_done", frame_done, efd[i]);
            check("err", err, (i >= err_from) ? 1 : 0);
        end
    end

    task automatic drive_pair(input int k);
        r0_in = pix[0][2*k];   g0_in = pix[1][2*k];   b0_in = pix[2][2*k];
        r1_in = pix[0][2*k+1]; g1_in = pix[1][2*k+1]; b1_in = pix[2][2*k+1];
    endtask

    // Called #1 after a rising edge; npairs < P models hsync dropping mid-line.
    task automatic send_line(input int npairs, input bit en_line, input bit toggle);
        int m, w, c;
        m = cyc;
        w = 2 * npairs;
        for (int k = 0; k < npairs; k++) begin
            c = m + 2 + k;
            ev[c] = 1'b1;
            for (int ch = 0; ch < 3; ch++) begin
                ed[c][ch]     = en_line ? 8'(smooth(ch, 2*k, w))     : pix[ch][2*k];
                ed[c][3 + ch] = en_line ? 8'(smooth(ch, 2*k + 1, w)) : pix[ch][2*k+1];
            end
            eline[c] = model_line;
            efd[c]   = (k == npairs - 1) && (model_line == H - 1);
        end
        if (npairs < P && m + 1 + npairs < err_from) err_from = m + 1 + npairs;
        model_line = (model_line + 1) % H;
        for (int k = 0; k < npairs; k++) begin
            en = (k > 0 && toggle) ? !en_line : en_line;
            hsync_in = 1'b1;
            drive_pair(k);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        hsync_in = 1'b0;
        {r0_in, g0_in, b0_in, r1_in, g1_in, b1_in} = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill(input int v);
        for (int ch = 0; ch < 3; ch++)
            for (int p = 0; p < W; p++) pix[ch][p] = 8'(v);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        hsync_in = 1'b0;
        {r0_in, g0_in, b0_in, r1_in, g1_in, b1_in} = '0;
        repeat (2) @(posedge clk);
        #1;
        checking = 1'b1;
        check("rst_hsync_out", hsync_out, 0);
        check("rst_line_cnt", line_cnt, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Flat frame: two back-to-back lines, frame_done on the 8th output pair.
        fill(100);
        send_line(P, 1'b1, 1'b0);
        send_line(P, 1'b1, 1'b0);
        idle(3);

        // Ramp on R with other patterns on G/B.
        for (int p = 0; p < W; p++) begin
            pix[0][p] = 8'(p);
            pix[1][p] = 8'(30 * p);
            pix[2][p] = 8'(255 - 20 * p);
        end
        check("pin_ramp0", smooth(0, 0, W), 0);
        check("pin_ramp7", smooth(0, 7, W), 7);
        send_line(P, 1'b1, 1'b0);
        idle(3);

        // Impulse on G crossing the pair boundary.
        fill(0);
        pix[1][3] = 8'd255;
        check("pin_imp2", smooth(1, 2, W), 64);
        check("pin_imp3", smooth(1, 3, W), 128);
        check("pin_imp4", smooth(1, 4, W), 64);
        send_line(P, 1'b1, 1'b0);
        idle(3);

        fill(255);
        check("pin_max", smooth(0, 4, W), 255);
        send_line(P, 1'b1, 1'b0);
        idle(3);

        fill(0);
        for (int ch = 0; ch < 3; ch++) begin
            pix[ch][0]     = 8'd255;
            pix[ch][W - 1] = 8'd255;
        end
        check("pin_edge0", smooth(0, 0, W), 191);
        check("pin_edge7", smooth(2, 7, W), 191);
        send_line(P, 1'b1, 1'b0);
        idle(3);

        // Pass-through then smoothed, back-to-back, en toggled mid-line.
        for (int ch = 0; ch < 3; ch++)
            for (int p = 0; p < W; p++) pix[ch][p] = 8'($urandom_range(0, 255));
        send_line(P, 1'b0, 1'b1);
        send_line(P, 1'b1, 1'b1);
        idle(3);

        // hsync drop after two pairs.
        for (int ch = 0; ch < 3; ch++)
            for (int p = 0; p < W; p++) pix[ch][p] = 8'(10 * p + ch);
        send_line(2, 1'b1, 1'b0);
        idle(4);

        // Reset mid-line, before any output of that line.
        en = 1'b1;
        hsync_in = 1'b1;
        drive_pair(0);
        @(posedge clk);
        #1;
        drive_pair(1);
        rst = 1'b1;
        err_from = NEVER;
        model_line = 0;
        @(posedge clk);
        #1;
        check("rstmid_hsync_out", hsync_out, 0);
        check("rstmid_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);
        check("rstmid_line_cnt", line_cnt, 0);

        fill(77);
        pix[0][5] = 8'd1;
        send_line(P, 1'b1, 1'b0);
        idle(4);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
